fft_twiddle_mult: RTL and testbench

Pipelined complex twiddle multiplier placed directly downstream of the free-running coefficient ROM sequencer in each FFT butterfly lane. It multiplies each valid input sample by the twiddle word presented in the same cycle. It rounds and (optionally) saturates the product back to NBITS per component, tracks the in-frame sample index modulo N, and flags the last sample of each frame for the next butterfly stage.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_cmult.sv | 62 ++++++
 rtl/fft_twiddle_mult.sv | 63 ++++++
 tb/tb_fft_twiddle_mult.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, complex re/im extraction and rounding constant for FFT lanes
package fft_pkg;
  localparam int NBITS_DEF = 16;
  localparam int N_DEF = 8;
  localparam int MAXB = 24;
  function automatic logic signed [MAXB-1:0] re_of(input logic [2*MAXB-1:0] x, input int nb);
    logic signed [MAXB-1:0] v;
    v = MAXB'(x >> nb);
    return (v <<< (MAXB - nb)) >>> (MAXB - nb);
  endfunction
  function automatic logic signed [MAXB-1:0] im_of(input logic [2*MAXB-1:0] x, input int nb);
    logic signed [MAXB-1:0] v;
    v = MAXB'(x);
    return (v <<< (MAXB - nb)) >>> (MAXB - nb);
  endfunction
  function automatic longint rnd_const(input int nb);
    return longint'(1) << (nb - 2);
  endfunction
endpackage

// File: rtl/fft_cmult.sv
// fft_cmult: registered complex product, round half up, reduce to NBITS
// Build option TWIDDLE_SAT_EN: clamp overflowing components instead of wrapping.
module fft_cmult
  import fft_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en2,
  input  logic               en3,
  input  logic [2*NBITS-1:0] x,
  input  logic [2*NBITS-1:0] w,
  output logic [2*NBITS-1:0] y,
  output logic               ovf_det
);
  localparam int PW = 2 * NBITS;
  localparam int SW = 2 * NBITS + 1;
  localparam logic signed [SW-1:0] MAXV = SW'((longint'(1) << (NBITS - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic signed [SW-1:0] RND = SW'(rnd_const(NBITS));
  logic signed [NBITS-1:0] a, b, c, d;
  logic signed [PW-1:0] ac, bd, ad, bc;
  logic signed [SW-1:0] qr, qi;
  assign a = NBITS'(re_of((2*MAXB)'(x), NBITS));
  assign b = NBITS'(im_of((2*MAXB)'(x), NBITS));
  assign c = NBITS'(re_of((2*MAXB)'(w), NBITS));
  assign d = NBITS'(im_of((2*MAXB)'(w), NBITS));
  function automatic logic ovr(input logic signed [SW-1:0] q);
    return q > MAXV || q < MINV;
  endfunction
  function automatic logic [NBITS-1:0] red(input logic signed [SW-1:0] q);
`ifdef TWIDDLE_SAT_EN
    return ovr(q) ? (q[SW-1] ? NBITS'(MINV) : NBITS'(MAXV)) : q[NBITS-1:0];
`else
    return q[NBITS-1:0];
`endif
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      ac <= '0;
      bd <= '0;
      ad <= '0;
      bc <= '0;
    end else if (en2) begin
      ac <= a * c;
      bd <= b * d;
      ad <= a * d;
      bc <= b * c;
    end
  end
  // full-precision sums fit in 2*NBITS+1 bits even with the rounding term added
  always_comb begin
    qr = (SW'(ac) - SW'(bd) + RND) >>> (NBITS - 1);
    qi = (SW'(ad) + SW'(bc) + RND) >>> (NBITS - 1);
  end
  assign ovf_det = ovr(qr) | ovr(qi);
  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else if (en3) y <= {red(qr), red(qi)};
  end
endmodule

// File: rtl/fft_twiddle_mult.sv
// fft_twiddle_mult: 3-stage twiddle multiplier with in-frame index, last flag and sticky overflow
// Build option TWIDDLE_SAT_EN (in fft_cmult) selects saturating reduction.
module fft_twiddle_mult
  import fft_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int N = N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*NBITS-1:0]   din,
  input  logic                 din_valid,
  input  logic [2*NBITS-1:0]   coeff_in,
  output logic [2*NBITS-1:0]   dout,
  output logic                 dout_valid,
  output logic [$clog2(N)-1:0] dout_index,
  output logic                 dout_last,
  output logic                 ovf
);
  localparam int IW = $clog2(N);
  logic [2*NBITS-1:0] din_q, coeff_q;
  logic v1, v2, ovf_det;
  logic [IW-1:0] cnt, idx1, idx2;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx1 <= '0;
      idx2 <= '0;
      din_q <= '0;
      coeff_q <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      dout_valid <= 1'b0;
      dout_index <= '0;
      dout_last <= 1'b0;
      ovf <= 1'b0;
    end else begin
      v1 <= din_valid;
      v2 <= v1;
      dout_valid <= v2;
      dout_last <= v2 && idx2 == IW'(N - 1);
      ovf <= ovf | (v2 & ovf_det);
      if (din_valid) begin
        din_q <= din;
        coeff_q <= coeff_in;
        idx1 <= cnt;
        cnt <= cnt + 1'b1;
      end
      if (v1) idx2 <= idx1;
      if (v2) dout_index <= idx2;
    end
  end
  fft_cmult #(.NBITS(NBITS)) u_cmult (
    .clk(clk),
    .rst(rst),
    .en2(v1),
    .en3(v2),
    .x(din_q),
    .w(coeff_q),
    .y(dout),
    .ovf_det(ovf_det)
  );
endmodule

// File: tb/tb_fft_twiddle_mult.sv
// tb_fft_twiddle_mult: scoreboard bench for fft_twiddle_mult (NBITS=16, N=8)
module tb_fft_twiddle_mult;
  localparam int NB = 16;
  localparam int NN = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] coeff_in = '0;
  logic [31:0] dout;
  logic dout_valid, dout_last, ovf;
  logic [2:0] dout_index;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sidx = 0;
  int nlast = 0;
  logic exp_ovf = 1'b0;
  typedef struct {
    logic [31:0] d;
    int idx;
    logic last;
    logic o;
    int t;
  } exp_t;
  exp_t q[$];

  fft_twiddle_mult #(.NBITS(NB), .N(NN)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .coeff_in(coeff_in),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_index(dout_index),
    .dout_last(dout_last),
    .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] red16(input longint v);
`ifdef TWIDDLE_SAT_EN
    return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] c, output logic o);
    longint a, b, x, y, re, im;
    a = longint'($signed(d[31:16]));
    b = longint'($signed(d[15:0]));
    x = longint'($signed(c[31:16]));
    y = longint'($signed(c[15:0]));
    re = (a * x - b * y + 16384) >>> 15;
    im = (a * y + b * x + 16384) >>> 15;
    o = re > 32767 || re < -32768 || im > 32767 || im < -32768;
    return {red16(re), red16(im)};
  endfunction

  function automatic logic [15:0] rs();
    logic [15:0] r;
    r = 16'($urandom_range(0, 32767));
    return r - 16'h4000;
  endfunction

  task automatic send(input logic [31:0] d, input logic [31:0] c);
    exp_t e;
    logic o;
    din = d;
    coeff_in = c;
    din_valid = 1'b1;
    e.d = model(d, c, o);
    e.o = o;
    e.idx = sidx;
    e.last = sidx == NN - 1;
    e.t = cyc;
    q.push_back(e);
    sidx = (sidx + 1) % NN;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic with_valid);
    rst = 1'b1;
    din = 32'h12345678;
    coeff_in = 32'h40000000;
    din_valid = with_valid;
    @(posedge clk);
    q.delete();
    sidx = 0;
    exp_ovf = 1'b0;
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        exp_ovf = exp_ovf | e.o;
        chk("dout", dout, e.d);
        chk("index", dout_index, e.idx);
        chk("last", dout_last, e.last);
        chk("latency", cyc - e.t, 3);
        chk("ovf", ovf, exp_ovf);
        if (dout_last) nlast++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset(1'b1);
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_index", dout_index, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    send(32'h20001000, 32'h40000000);
    send(32'h20001000, 32'h0000C000);
    send(32'h00010000, 32'h40000000);
    idle(5);
    chk("ovf_clean", ovf, 0);
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      send({rs(), rs()}, {rs(), rs()});
      if (i == 5) idle(2);
    end
    idle(5);
    chk("last_count", nlast, 2);
    chk("ovf_clean2", ovf, 0);
    send({rs(), rs()}, {rs(), rs()});
    send({rs(), rs()}, {rs(), rs()});
    send({rs(), rs()}, {rs(), rs()});
    do_reset(1'b0);
    idle(4);
    send({rs(), rs()}, {rs(), rs()});
    idle(5);
    send(32'h80008000, 32'h80008000);
    send(32'h20001000, 32'h40000000);
    idle(5);
    chk("ovf_sticky", ovf, 1);
    do_reset(1'b0);
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
